// File: rtl/lcd_hd44780_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_hd44780_ctrl
//  Purpose  : Write-only HD44780 character-LCD controller. Runs the power-on
//             init sequence on its own, then accepts bytes over a
//             valid/ready handshake and strobes them onto the LCD bus with
//             setup, enable-high, hold and execution-wait timing.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_ctrl #(
   parameter int T_POWERUP   = 750000,
   parameter int T_SETUP     = 2,
   parameter int T_EN_HIGH   = 25,
   parameter int T_HOLD      = 2,
   parameter int T_EXEC      = 2000,
   parameter int T_EXEC_LONG = 82000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       lcd_en
);

   // A timing value of 0 still has to last one cycle.
   localparam int c_PU = (T_POWERUP   < 1) ? 1 : T_POWERUP;
   localparam int c_SU = (T_SETUP     < 1) ? 1 : T_SETUP;
   localparam int c_EN = (T_EN_HIGH   < 1) ? 1 : T_EN_HIGH;
   localparam int c_HO = (T_HOLD      < 1) ? 1 : T_HOLD;
   localparam int c_EX = (T_EXEC      < 1) ? 1 : T_EXEC;
   localparam int c_EL = (T_EXEC_LONG < 1) ? 1 : T_EXEC_LONG;

   // Widest interval decides the width of the shared counter.
   localparam int c_MAX_A = (c_PU    > c_SU) ? c_PU    : c_SU;
   localparam int c_MAX_B = (c_MAX_A > c_EN) ? c_MAX_A : c_EN;
   localparam int c_MAX_C = (c_MAX_B > c_HO) ? c_MAX_B : c_HO;
   localparam int c_MAX_D = (c_MAX_C > c_EX) ? c_MAX_C : c_EX;
   localparam int c_MAX   = (c_MAX_D > c_EL) ? c_MAX_D : c_EL;
   localparam int c_CW    = $clog2(c_MAX) + 1;

   // Each load is the interval minus one so a state lasts exactly its interval.
   localparam logic [c_CW-1:0] c_PU_LAST = c_CW'(c_PU - 1);
   localparam logic [c_CW-1:0] c_SU_LOAD = c_CW'(c_SU - 1);
   localparam logic [c_CW-1:0] c_EN_LOAD = c_CW'(c_EN - 1);
   localparam logic [c_CW-1:0] c_HO_LOAD = c_CW'(c_HO - 1);
   localparam logic [c_CW-1:0] c_EX_LOAD = c_CW'(c_EX - 1);
   localparam logic [c_CW-1:0] c_EL_LOAD = c_CW'(c_EL - 1);
   localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
   localparam logic [2:0]      c_INIT_END = 3'd7;

   typedef enum logic [2:0] {
      S_POWERUP   = 3'd0,
      S_INIT_LOAD = 3'd1,
      S_SETUP     = 3'd2,
      S_PULSE     = 3'd3,
      S_HOLD      = 3'd4,
      S_WAIT      = 3'd5,
      S_IDLE      = 3'd6
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [c_CW-1:0]   r_cnt;
   logic [c_CW-1:0]   w_cnt_next;
   logic [2:0]        r_init_idx;     // next init entry to issue; 7 = all issued
   logic              r_in_init;
   logic              r_long;         // current byte needs the long execution wait
   logic              r_lcd_rs;
   logic [7:0]        r_lcd_data;
   logic              r_lcd_en;
   logic              r_cmd_ready;
   logic              r_busy;
   logic              r_init_done;
   logic              w_load_init;
   logic              w_accept;
   logic              w_finish_init;
   logic [7:0]        w_init_byte;

   // Power-on init table indexed by the entry counter.
   always_comb begin
      w_init_byte = 8'h0C;
      case (r_init_idx)
         3'd0, 3'd1, 3'd2: w_init_byte = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
         3'd3:             w_init_byte = 8'h08;   // display off
         3'd4:             w_init_byte = 8'h01;   // clear
         3'd5:             w_init_byte = 8'h06;   // entry mode: increment, no shift
         default:          w_init_byte = 8'h0C;   // display on, cursor off
      endcase
   end

   // Next-state, counter reload and byte-load decisions.
   // Init entries are loaded on the transition into SETUP, so an init entry
   // costs the same SETUP+PULSE+HOLD+WAIT budget as a host byte; S_INIT_LOAD
   // is only entered if the state register is ever disturbed.
   always_comb begin
      w_next        = r_state;
      w_cnt_next    = r_cnt;
      w_load_init   = 1'b0;
      w_accept      = 1'b0;
      w_finish_init = 1'b0;
      case (r_state)
         S_POWERUP: begin
            // Elapsed-time count starting from the reset cycle.
            if (r_cnt == c_PU_LAST) begin
               w_next      = S_SETUP;
               w_cnt_next  = c_SU_LOAD;
               w_load_init = 1'b1;
            end else begin
               w_cnt_next = r_cnt + c_CNT_ONE;
            end
         end
         S_INIT_LOAD: begin
            w_next      = S_SETUP;
            w_cnt_next  = c_SU_LOAD;
            w_load_init = 1'b1;
         end
         S_SETUP: begin
            if (r_cnt == '0) begin
               w_next     = S_PULSE;
               w_cnt_next = c_EN_LOAD;
            end else begin
               w_cnt_next = r_cnt - c_CNT_ONE;
            end
         end
         S_PULSE: begin
            if (r_cnt == '0) begin
               w_next     = S_HOLD;
               w_cnt_next = c_HO_LOAD;
            end else begin
               w_cnt_next = r_cnt - c_CNT_ONE;
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               w_next     = S_WAIT;
               w_cnt_next = r_long ? c_EL_LOAD : c_EX_LOAD;
            end else begin
               w_cnt_next = r_cnt - c_CNT_ONE;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               if (r_in_init && (r_init_idx != c_INIT_END)) begin
                  w_next      = S_SETUP;
                  w_cnt_next  = c_SU_LOAD;
                  w_load_init = 1'b1;
               end else begin
                  w_next        = S_IDLE;
                  w_cnt_next    = '0;
                  w_finish_init = r_in_init;
               end
            end else begin
               w_cnt_next = r_cnt - c_CNT_ONE;
            end
         end
         S_IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_next     = S_SETUP;
               w_cnt_next = c_SU_LOAD;
               w_accept   = 1'b1;
            end
         end
         default: begin
            w_next     = S_POWERUP;
            w_cnt_next = '0;
         end
      endcase
   end

   // State and shared counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_POWERUP;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Latch the byte to send (init entry or accepted host byte) and its wait class.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lcd_rs   <= 1'b0;
         r_lcd_data <= 8'h00;
         r_long     <= 1'b0;
         r_init_idx <= 3'd0;
      end else if (w_load_init) begin
         r_lcd_rs   <= 1'b0;
         r_lcd_data <= w_init_byte;
         r_long     <= 1'b1;
         r_init_idx <= r_init_idx + 3'd1;
      end else if (w_accept) begin
         r_lcd_rs   <= cmd_rs;
         r_lcd_data <= cmd_data;
         // Clear (0x01) and home (0x02/0x03) are the slow instructions.
         r_long     <= (!cmd_rs) && (cmd_data[7:2] == 6'd0);
      end
   end

   // Init-progress flag and the sticky completion flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_in_init   <= 1'b1;
         r_init_done <= 1'b0;
      end else if (w_finish_init) begin
         r_in_init   <= 1'b0;
         r_init_done <= 1'b1;
      end
   end

   // Registered strobes and status decoded from the upcoming state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lcd_en    <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_lcd_en    <= (w_next == S_PULSE);
         r_cmd_ready <= (w_next == S_IDLE);
         r_busy      <= (w_next != S_IDLE);
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign init_done = r_init_done;
   assign busy      = r_busy;
   assign lcd_rs    = r_lcd_rs;
   assign lcd_rw    = 1'b0;
   assign lcd_data  = r_lcd_data;
   assign lcd_en    = r_lcd_en;

endmodule
`default_nettype wire
